// File: rtl/rtc_counter_p.sv
// rtc_counter_p: time-of-day counter with internal seconds prescaler.
// Tracks HH:MM:SS, day rollover, 12/24 h display and alarm match.
module rtc_counter_p #(
    parameter int TICK_DIV = 1000,
    parameter int DAY_W    = 9
) (
    input  logic             clk_1kHz,
    input  logic             resetn,
    input  logic             i_run_toggle,
    input  logic             i_mode12_toggle,
    input  logic             i_load_sig,
    input  logic [20:0]      i_load_data,
    input  logic             i_inc,
    input  logic [1:0]       i_inc_field,
    input  logic             i_alarm_en,
    input  logic [20:0]      i_alarm_time,
    output logic [20:0]      o_current_time,
    output logic [6:0]       o_hour_disp,
    output logic             o_ampm,
    output logic             o_mode12,
    output logic             o_stopped,
    output logic             o_sec_tick,
    output logic [DAY_W-1:0] o_day_count,
    output logic             o_load_err,
    output logic             o_alarm
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);

    logic [6:0]       hour;
    logic [6:0]       minute;
    logic [6:0]       second;
    logic [PW-1:0]    presc;
    logic [DAY_W-1:0] day;
    logic             mode12;
    logic             stopped;
    logic             sec_tick;
    logic             load_err;
    logic             alarm;

    logic [6:0]       ld_h;
    logic [6:0]       ld_m;
    logic [6:0]       ld_s;
    logic             load_ok;
    logic             running;
    logic             tick;
    logic             inc_act;
    logic [PW-1:0]    presc_nxt;
    logic [6:0]       nxt_h;
    logic [6:0]       nxt_m;
    logic [6:0]       nxt_s;
    logic             roll;

    assign ld_h    = i_load_data[20:14];
    assign ld_m    = i_load_data[13:7];
    assign ld_s    = i_load_data[6:0];
    assign load_ok = (ld_h <= 7'd23) && (ld_m <= 7'd59) && (ld_s <= 7'd59);

    // A run toggle freezes or releases the prescaler on the same edge
    assign running   = ~(stopped ^ i_run_toggle);
    assign presc_nxt = (presc == P_MAX) ? '0 : presc + 1'b1;
    assign tick      = running && (presc == P_MAX);
    assign inc_act   = i_inc && (i_inc_field != 2'b00);

    // One-second advance with full carry chain into the day counter
    always_comb begin
        nxt_h = hour;
        nxt_m = minute;
        nxt_s = second;
        roll  = 1'b0;
        if (second == 7'd59) begin
            nxt_s = 7'd0;
            if (minute == 7'd59) begin
                nxt_m = 7'd0;
                if (hour == 7'd23) begin
                    nxt_h = 7'd0;
                    roll  = 1'b1;
                end else begin
                    nxt_h = hour + 7'd1;
                end
            end else begin
                nxt_m = minute + 7'd1;
            end
        end else begin
            nxt_s = second + 7'd1;
        end
    end

    // Time state: reset, then load, then field increment, then tick
    always_ff @(posedge clk_1kHz) begin
        if (!resetn) begin
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            presc    <= '0;
            day      <= '0;
            mode12   <= 1'b0;
            stopped  <= 1'b0;
            sec_tick <= 1'b0;
            load_err <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            load_err <= 1'b0;
            alarm    <= 1'b0;
            if (i_run_toggle) stopped <= ~stopped;
            if (i_mode12_toggle) mode12 <= ~mode12;
            if (i_load_sig) begin
                if (load_ok) begin
                    hour   <= ld_h;
                    minute <= ld_m;
                    second <= ld_s;
                    presc  <= '0;
                    day    <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (inc_act) begin
                case (i_inc_field)
                    2'b01: hour <= (hour == 7'd23) ? 7'd0 : hour + 7'd1;
                    2'b10: minute <= (minute == 7'd59) ? 7'd0 : minute + 7'd1;
                    default: second <= (second == 7'd59) ? 7'd0 : second + 7'd1;
                endcase
                if (i_inc_field == 2'b11) presc <= '0;
                else if (running) presc <= presc_nxt;
            end else if (running) begin
                presc <= presc_nxt;
                if (tick) begin
                    hour     <= nxt_h;
                    minute   <= nxt_m;
                    second   <= nxt_s;
                    sec_tick <= 1'b1;
                    alarm    <= i_alarm_en &&
                                ({nxt_h, nxt_m, nxt_s} == i_alarm_time);
                    if (roll) day <= day + 1'b1;
                end
            end
        end
    end

    // 12 h display conversion from the registered hour
    always_comb begin
        o_hour_disp = hour;
        if (mode12) begin
            if (hour == 7'd0) o_hour_disp = 7'd12;
            else if (hour > 7'd12) o_hour_disp = hour - 7'd12;
        end
    end

    assign o_ampm         = (hour >= 7'd12);
    assign o_current_time = {hour, minute, second};
    assign o_mode12       = mode12;
    assign o_stopped      = stopped;
    assign o_sec_tick     = sec_tick;
    assign o_day_count    = day;
    assign o_load_err     = load_err;
    assign o_alarm        = alarm;

endmodule
